keccak_obi_read_master: RTL and testbench

//  OBI read initiator for an external-xbar master port of x_heep_system
//  (ext_xbar_master_req_i/ext_xbar_master_resp_o). It fetches a block of
//  32-bit words from system memory, e.g. a Keccak message buffer, with

---
 rtl/keccak_obi_read_master.sv | 193 +++++++++++++++++++
 tb/tb_keccak_obi_read_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_obi_read_master.sv
// OBI read initiator: fetches a block of 32-bit words with pipelined,
// credit-limited requests and streams them out in address order through a
// small read-data FIFO that absorbs sink backpressure.

package keccak_obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module keccak_obi_read_master
   import keccak_obi_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [CNT_W-1:0] num_words_i,
   output logic             busy_o,
   output logic             done_o,
   output obi_req_t         obi_req_o,
   input  obi_resp_t        obi_resp_i,
   output logic [31:0]      data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W  = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [CNT_W-1:0]   returned_q, returned_d;
   logic [CNT_W-1:0]   popped_q, popped_d;
   logic               req_q, req_d;

   logic [31:0]        fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0]  fcount_q, fcount_d;

   logic               hs;
   logic               push;
   logic               pop;
   logic [SUM_W-1:0]   inflight;

   // Circular pointer advance that also works for non power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A read is accepted on req&&gnt; a stray rvalid (nothing outstanding) is dropped.
   assign hs   = req_q & obi_resp_i.gnt;
   assign push = obi_resp_i.rvalid & (issued_q != returned_q);
   assign pop  = valid_o & ready_i;

   // Next-state, counter updates and request credit decision.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      num_d      = num_q;
      issued_d   = issued_q + CNT_W'(hs);
      returned_d = returned_q + CNT_W'(push);
      popped_d   = popped_q + CNT_W'(pop);
      fcount_d   = fcount_q + FCNT_W'(push) - FCNT_W'(pop);
      req_d      = 1'b0;
      if (hs) begin
         addr_d = addr_q + 32'd4;
      end
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               num_d      = num_words_i;
               addr_d     = src_addr_i & 32'hFFFF_FFFC;
               issued_d   = '0;
               returned_d = '0;
               popped_d   = '0;
               state_d    = (num_words_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (hs && (issued_d == num_q)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (popped_q == num_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Words in flight plus words parked in the FIFO must leave room for one more.
      inflight = SUM_W'(issued_d - returned_d) + SUM_W'(fcount_d);
      if (req_q && !obi_resp_i.gnt) begin
         req_d = 1'b1;
      end else begin
         req_d = (state_d == S_RUN) && (issued_d != num_d) &&
                 (inflight < SUM_W'(FIFO_DEPTH));
      end
   end

   // Control and address/counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         returned_q <= '0;
         popped_q   <= '0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         returned_q <= returned_d;
         popped_q   <= popped_d;
         req_q      <= req_d;
      end
   end

   // Read-data FIFO: push on accepted rvalid, pop on stream handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcount_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= obi_resp_i.rdata;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         fcount_q <= fcount_d;
      end
   end

   assign obi_req_o.req   = req_q;
   assign obi_req_o.we    = 1'b0;
   assign obi_req_o.be    = 4'hF;
   assign obi_req_o.addr  = addr_q;
   assign obi_req_o.wdata = '0;

   assign data_o  = fifo_q[rd_ptr_q];
   assign valid_o = (fcount_q != '0);
   assign busy_o  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o  = (state_q == S_DONE);

   a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
      obi_resp_i.rvalid |-> (issued_q != returned_q))
      else $error("rvalid with no outstanding read");

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      (push && !pop) |-> (fcount_q < FCNT_W'(FIFO_DEPTH)))
      else $error("read-data FIFO overflow");

endmodule

// File: tb/tb_keccak_obi_read_master.sv
// Bench for keccak_obi_read_master: randomized OBI slave with a lazily
// filled word memory, and scenario tasks checking address order, data
// order, credit limit, request stability, done pulse and reset.

module tb_keccak_obi_read_master;
   import keccak_obi_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      src = '0;
   logic [CNT_W-1:0] num = '0;
   logic             busy, done, valid;
   logic [31:0]      data;
   obi_req_t         oreq;
   obi_resp_t        oresp = '0;
   logic             ready = 1'b0;

   keccak_obi_read_master #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .src_addr_i(src),
      .num_words_i(num), .busy_o(busy), .done_o(done), .obi_req_o(oreq),
      .obi_resp_i(oresp), .data_o(data), .valid_o(valid), .ready_i(ready));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // slave behaviour knobs
   int gnt_prob = 100, stall_n = 0, dmin = 1, dmax = 1, ready_prob = 100;

   // observation log (only ever appended by the slave/monitor process)
   logic [31:0] g_addr[$];
   int          g_cyc[$];
   logic [31:0] p_data[$];
   int done_cnt = 0, done_cyc = 0, busy_cnt = 0, req_cnt = 0;
   int v_stable = 0, v_credit = 0, v_const = 0, cred_base = 0;

   logic [31:0] pend_data[$];
   int          pend_due[$];
   logic [31:0] mem [logic [31:0]];

   typedef struct { int g, p, d, b, r, vs, vc, vk; } mon_t;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   // OBI slave + stream sink + protocol monitor, all acting on the falling edge
   logic        prev_req = 1'b0, prev_gnt = 1'b0;
   logic [31:0] prev_addr = '0;
   int          req_age = 0;
   int          due;
   always @(negedge clk) begin
      if (oreq.we !== 1'b0 || oreq.be !== 4'hF || oreq.wdata !== 32'h0) v_const++;
      if (rst) begin
         pend_data.delete();
         pend_due.delete();
         oresp.gnt = 1'b0;
         oresp.rvalid = 1'b0;
         prev_req = 1'b0;
         prev_gnt = 1'b0;
         req_age = 0;
         cred_base = g_addr.size() - p_data.size();
      end else begin
         if (prev_req && !prev_gnt && (oreq.req !== 1'b1 || oreq.addr !== prev_addr)) v_stable++;
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            oresp.rvalid = 1'b1;
            oresp.rdata = pend_data.pop_front();
            void'(pend_due.pop_front());
         end else begin
            oresp.rvalid = 1'b0;
            oresp.rdata = $urandom;
         end
         if (oreq.req === 1'b1) begin
            req_cnt++;
            if (g_addr.size() - p_data.size() - cred_base >= FIFO_DEPTH) v_credit++;
            if (stall_n > 0) oresp.gnt = (req_age >= stall_n);
            else oresp.gnt = (int'($urandom_range(99)) < gnt_prob);
            if (oresp.gnt) begin
               req_age = 0;
               g_addr.push_back(oreq.addr);
               g_cyc.push_back(cyc);
               due = cyc + int'($urandom_range(dmax, dmin));
               pend_due.push_back(due);
               pend_data.push_back(word_at(oreq.addr));
            end else begin
               req_age++;
            end
         end else begin
            oresp.gnt = 1'($urandom_range(1));
            req_age = 0;
         end
         ready = (int'($urandom_range(99)) < ready_prob);
         if (valid === 1'b1 && ready) p_data.push_back(data);
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy === 1'b1) busy_cnt++;
         prev_req = oreq.req;
         prev_gnt = oresp.gnt;
         prev_addr = oreq.addr;
      end
   end

   task automatic snap(output mon_t s);
      s.g = g_addr.size(); s.p = p_data.size(); s.d = done_cnt; s.b = busy_cnt;
      s.r = req_cnt; s.vs = v_stable; s.vc = v_credit; s.vk = v_const;
   endtask

   task automatic set_slave(input int gp, input int st, input int lo, input int hi, input int rp);
      gnt_prob = gp; stall_n = st; dmin = lo; dmax = hi; ready_prob = rp;
   endtask

   task automatic do_start(input logic [31:0] a, input int n, output int s_cyc);
      @(posedge clk); #1;
      src = a; num = CNT_W'(n); start = 1'b1; s_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done_cnt > d0) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
      checks++; if (oreq.req !== 1'b0 || oreq.addr !== 32'h0) begin errors++; $display("FAIL reset_req got req=%b addr=%h want 0/0", oreq.req, oreq.addr); end
      checks++; if (oreq.be !== 4'hF || oreq.we !== 1'b0 || oreq.wdata !== 32'h0) begin errors++; $display("FAIL reset_const got be=%h we=%b wdata=%h want F/0/0", oreq.be, oreq.we, oreq.wdata); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || oreq.req !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b req=%b want 0/0", busy, oreq.req); end
   endtask

   task automatic test_basic();
      mon_t s; int sc; bit to;
      set_slave(100, 0, 1, 1, 100);
      snap(s);
      do_start(32'h100, 4, sc);
      wait_done(s.d, 200, to);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
      checks++; if (g_addr.size() - s.g != 4) begin errors++; $display("FAIL basic_nreads got %0d want 4", g_addr.size() - s.g); end
      for (int i = 0; i < 4 && s.g + i < g_addr.size(); i++) begin
         checks++; if (g_addr[s.g+i] !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, g_addr[s.g+i], 32'h100 + 32'(4*i)); end
         if (i > 0) begin
            checks++; if (g_cyc[s.g+i] - g_cyc[s.g+i-1] != 1) begin errors++; $display("FAIL basic_b2b%0d got gap %0d want 1", i, g_cyc[s.g+i] - g_cyc[s.g+i-1]); end
         end
      end
      checks++; if (p_data.size() - s.p != 4) begin errors++; $display("FAIL basic_nwords got %0d want 4", p_data.size() - s.p); end
      for (int i = 0; i < 4 && s.p + i < p_data.size(); i++) begin
         checks++; if (p_data[s.p+i] !== word_at(32'h100 + 32'(4*i))) begin errors++; $display("FAIL basic_data%0d got %h want %h", i, p_data[s.p+i], word_at(32'h100 + 32'(4*i))); end
      end
      checks++; if (done_cnt - s.d != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - s.d); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      mon_t s; int sc; bit to; logic [31:0] a;
      set_slave(100, 0, 1, 2, 0);
      snap(s);
      do_start(32'h2000, 8, sc);
      repeat (5) @(posedge clk);
      #1;
      // a start while busy must be ignored
      src = 32'hDEAD_0000; num = CNT_W'(3); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checks++; if (g_addr.size() - s.g != FIFO_DEPTH) begin errors++; $display("FAIL bp_stalled_reads got %0d want %0d", g_addr.size() - s.g, FIFO_DEPTH); end
      checks++; if (oreq.req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b want 0", oreq.req); end
      checks++; if (valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold got valid=%b busy=%b want 1/1", valid, busy); end
      ready_prob = 100;
      wait_done(s.d, 300, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
      checks++; if (g_addr.size() - s.g != 8 || p_data.size() - s.p != 8) begin errors++; $display("FAIL bp_counts got reads=%0d words=%0d want 8/8", g_addr.size() - s.g, p_data.size() - s.p); end
      for (int i = 0; i < 8 && s.p + i < p_data.size() && s.g + i < g_addr.size(); i++) begin
         a = 32'h2000 + 32'(4*i);
         checks++; if (g_addr[s.g+i] !== a || p_data[s.p+i] !== word_at(a)) begin errors++; $display("FAIL bp_word%0d got addr=%h data=%h want %h/%h", i, g_addr[s.g+i], p_data[s.p+i], a, word_at(a)); end
      end
      checks++; if (v_credit != s.vc || done_cnt - s.d != 1) begin errors++; $display("FAIL bp_credit_done got credit_viol=%0d done=%0d want 0/1", v_credit - s.vc, done_cnt - s.d); end
   endtask

   task automatic test_gnt_stall();
      mon_t s; int sc; bit to; logic [31:0] a;
      set_slave(100, 3, 1, 2, 100);
      snap(s);
      do_start(32'h3000, 5, sc);
      wait_done(s.d, 300, to);
      checks++; if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
      checks++; if (v_stable != s.vs) begin errors++; $display("FAIL stall_stable got %0d violations want 0", v_stable - s.vs); end
      checks++; if (g_addr.size() - s.g != 5 || p_data.size() - s.p != 5) begin errors++; $display("FAIL stall_counts got reads=%0d words=%0d want 5/5", g_addr.size() - s.g, p_data.size() - s.p); end
      for (int i = 0; i < 5 && s.p + i < p_data.size() && s.g + i < g_addr.size(); i++) begin
         a = 32'h3000 + 32'(4*i);
         checks++; if (g_addr[s.g+i] !== a || p_data[s.p+i] !== word_at(a)) begin errors++; $display("FAIL stall_word%0d got addr=%h data=%h want %h/%h", i, g_addr[s.g+i], p_data[s.p+i], a, word_at(a)); end
      end
      checks++; if (done_cnt - s.d != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt - s.d); end
      stall_n = 0;
   endtask

   task automatic test_zero();
      mon_t s; int sc;
      set_slave(100, 0, 1, 1, 100);
      snap(s);
      do_start(32'h5000, 0, sc);
      repeat (6) @(posedge clk);
      #1;
      checks++; if (done_cnt - s.d != 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt - s.d); end
      checks++; if (done_cyc - sc < 1 || done_cyc - sc > 2) begin errors++; $display("FAIL zero_done_time got %0d cycles want 1..2", done_cyc - sc); end
      checks++; if (busy_cnt != s.b || req_cnt != s.r) begin errors++; $display("FAIL zero_quiet got busy=%0d req=%0d cycles want 0/0", busy_cnt - s.b, req_cnt - s.r); end
   endtask

   task automatic test_wrap();
      mon_t s; int sc; bit to; logic [31:0] a;
      logic [31:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
      set_slave(60, 0, 1, 3, 70);
      snap(s);
      do_start(32'hFFFF_FFF8, 3, sc);
      wait_done(s.d, 300, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_timeout got no done want done"); end
      checks++; if (g_addr.size() - s.g != 3 || p_data.size() - s.p != 3) begin errors++; $display("FAIL wrap_counts got reads=%0d words=%0d want 3/3", g_addr.size() - s.g, p_data.size() - s.p); end
      for (int i = 0; i < 3 && s.p + i < p_data.size() && s.g + i < g_addr.size(); i++) begin
         a = exp_a[i];
         checks++; if (g_addr[s.g+i] !== a || p_data[s.p+i] !== word_at(a)) begin errors++; $display("FAIL wrap_word%0d got addr=%h data=%h want %h/%h", i, g_addr[s.g+i], p_data[s.p+i], a, word_at(a)); end
      end
   endtask

   task automatic test_abort();
      mon_t s; int sc; bit to; bit seen; logic [31:0] a;
      set_slave(100, 0, 6, 6, 100);
      snap(s);
      do_start(32'h6000, 8, sc);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (g_addr.size() - s.g >= 2) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL abort_setup got %0d reads want >=2", g_addr.size() - s.g); end
      #2 rst = 1'b1;
      #1;
      checks++; if (oreq.req !== 1'b0 || oreq.addr !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL abort_async got req=%b addr=%h busy=%b want 0/0/0", oreq.req, oreq.addr, busy); end
      checks++; if (valid !== 1'b0 || data !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL abort_stream got valid=%b data=%h done=%b want 0/0/0", valid, data, done); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      set_slave(100, 0, 1, 1, 100);
      snap(s);
      do_start(32'h7000, 6, sc);
      wait_done(s.d, 300, to);
      checks++; if (to || p_data.size() - s.p != 6) begin errors++; $display("FAIL abort_restart got timeout=%0d words=%0d want 0/6", to, p_data.size() - s.p); end
      for (int i = 0; i < 6 && s.p + i < p_data.size() && s.g + i < g_addr.size(); i++) begin
         a = 32'h7000 + 32'(4*i);
         checks++; if (g_addr[s.g+i] !== a || p_data[s.p+i] !== word_at(a)) begin errors++; $display("FAIL abort_word%0d got addr=%h data=%h want %h/%h", i, g_addr[s.g+i], p_data[s.p+i], a, word_at(a)); end
      end
   endtask

   task automatic test_random();
      mon_t s; int sc; bit to; int n; logic [31:0] a0, base, a;
      for (int t = 0; t < 8; t++) begin
         set_slave(int'($urandom_range(100, 30)), 0, 1, int'($urandom_range(4, 1)), int'($urandom_range(100, 20)));
         n = int'($urandom_range(20, 1));
         a0 = $urandom;
         base = a0 & 32'hFFFF_FFFC;
         snap(s);
         do_start(a0, n, sc);
         wait_done(s.d, 3000, to);
         checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got no done want done", t); end
         checks++; if (g_addr.size() - s.g != n || p_data.size() - s.p != n) begin errors++; $display("FAIL rand%0d_counts got reads=%0d words=%0d want %0d", t, g_addr.size() - s.g, p_data.size() - s.p, n); end
         for (int i = 0; i < n && s.p + i < p_data.size() && s.g + i < g_addr.size(); i++) begin
            a = base + 32'(4*i);
            checks++; if (g_addr[s.g+i] !== a || p_data[s.p+i] !== word_at(a)) begin errors++; $display("FAIL rand%0d_word%0d got addr=%h data=%h want %h/%h", t, i, g_addr[s.g+i], p_data[s.p+i], a, word_at(a)); end
         end
         checks++; if (v_stable != s.vs || v_credit != s.vc || v_const != s.vk) begin errors++; $display("FAIL rand%0d_protocol got stable=%0d credit=%0d const=%0d want 0/0/0", t, v_stable - s.vs, v_credit - s.vc, v_const - s.vk); end
         checks++; if (done_cnt - s.d != 1) begin errors++; $display("FAIL rand%0d_done got %0d want 1", t, done_cnt - s.d); end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_backpressure();
      test_gnt_stall();
      test_zero();
      test_wrap();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
